// File: rtl/chess_pkg.sv
// Shared definitions for the chess game: sides, scheduler states, chessman codes.
package chess_pkg;

    localparam logic WHITE_PLAYER = 1'b1;
    localparam logic BLACK_PLAYER = 1'b0;

    localparam logic [7:0] MOVE_COUNT_MAX = 8'd255;

    // Scheduler states; the encoding is visible on the GameState port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_COMMIT = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_OVER   = 3'd4
    } game_state_e;

    // Piece codes shared with the layout matrix.
    typedef enum logic [3:0] {
        CM_EMPTY  = 4'd0,
        CM_PAWN   = 4'd1,
        CM_KNIGHT = 4'd2,
        CM_BISHOP = 4'd3,
        CM_ROOK   = 4'd4,
        CM_QUEEN  = 4'd5,
        CM_KING   = 4'd6
    } chessman_e;

    // Move counter increment that sticks at its maximum.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == MOVE_COUNT_MAX) begin
            result = MOVE_COUNT_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/chess_turn_scheduler_if.sv
// Move-commit handshake between the layout matrix (master) and the turn scheduler (slave).
interface chess_turn_scheduler_if;
    logic MoveReq;
    logic MoveValid;
    logic MoveGrant;
    logic MoveReject;

    modport master (
        output MoveReq,
        output MoveValid,
        input  MoveGrant,
        input  MoveReject
    );

    modport slave (
        input  MoveReq,
        input  MoveValid,
        output MoveGrant,
        output MoveReject
    );
endinterface

// File: rtl/player_countdown.sv
// One player's remaining-seconds counter: floor at zero, saturating bonus add.
module player_countdown import chess_pkg::*; #(
    parameter int START_SECONDS     = 300,
    parameter int INCREMENT_SECONDS = 0,
    parameter int TIMER_WIDTH       = 10
) (
    input  logic                   OutClock,
    input  logic                   resetApp,
    input  logic                   en_i,
    input  logic                   dec_i,
    input  logic                   add_i,
    output logic [TIMER_WIDTH-1:0] seconds_o,
    output logic                   zero_o
);

    localparam logic [TIMER_WIDTH-1:0] START_VAL = TIMER_WIDTH'(START_SECONDS);
    localparam logic [TIMER_WIDTH:0]   INC_EXT   = (TIMER_WIDTH + 1)'(INCREMENT_SECONDS);
    localparam logic [TIMER_WIDTH:0]   SAT_MAX   = {1'b0, {TIMER_WIDTH{1'b1}}};

    logic [TIMER_WIDTH-1:0] seconds_q;
    logic [TIMER_WIDTH-1:0] seconds_d;
    logic [TIMER_WIDTH:0]   sum_s;
    logic                   zero_s;

    assign zero_s = (seconds_q == {TIMER_WIDTH{1'b0}});
    assign sum_s  = {1'b0, seconds_q} + INC_EXT;

    // Next seconds value: add has priority, decrement never goes below zero.
    always_comb begin
        seconds_d = seconds_q;
        if (en_i && add_i) begin
            if (sum_s > SAT_MAX) begin
                seconds_d = SAT_MAX[TIMER_WIDTH-1:0];
            end else begin
                seconds_d = sum_s[TIMER_WIDTH-1:0];
            end
        end else if (en_i && dec_i && !zero_s) begin
            seconds_d = seconds_q - TIMER_WIDTH'(1);
        end else begin
            seconds_d = seconds_q;
        end
    end

    // Seconds register, reloaded with the starting time on reset.
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            seconds_q <= START_VAL;
        end else begin
            seconds_q <= seconds_d;
        end
    end

    assign seconds_o = seconds_q;
    assign zero_o    = zero_s;

endmodule

// File: rtl/chess_turn_scheduler.sv
// Turn scheduler and game clock: arbitrates move commits and runs both countdowns.
module chess_turn_scheduler import chess_pkg::*; #(
    parameter int TICKS_PER_SECOND  = 10,
    parameter int START_SECONDS     = 300,
    parameter int INCREMENT_SECONDS = 0,
    parameter int TIMER_WIDTH       = 10
) (
    input  logic                   OutClock,
    input  logic                   resetApp,
    input  logic                   StartGame,
    input  logic                   PauseSwitch,
    chess_turn_scheduler_if.slave  move_bus,
    output logic                   Player,
    output logic [TIMER_WIDTH-1:0] WhiteSeconds,
    output logic [TIMER_WIDTH-1:0] BlackSeconds,
    output logic [7:0]             MoveCount,
    output logic [2:0]             GameState,
    output logic                   Winner
);

    localparam int TICK_W = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SECOND - 1);

    game_state_e            state_q,  state_d;
    logic                   player_q, player_d;
    logic [TICK_W-1:0]      tick_q,   tick_d;
    logic [7:0]             count_q,  count_d;
    logic                   grant_q,  grant_d;
    logic                   reject_q, reject_d;
    logic                   winner_q, winner_d;

    logic                   dec_s;
    logic                   add_s;
    logic                   tick_wrap_s;
    logic                   mover_last_s;
    logic [TIMER_WIDTH-1:0] white_secs_s;
    logic [TIMER_WIDTH-1:0] black_secs_s;
    logic [TIMER_WIDTH-1:0] mover_secs_s;
    logic                   white_zero_s;
    logic                   black_zero_s;
    logic                   mover_zero_s;

    assign tick_wrap_s  = (tick_q == TICK_LAST);
    assign mover_secs_s = (player_q == WHITE_PLAYER) ? white_secs_s : black_secs_s;
    assign mover_zero_s = (player_q == WHITE_PLAYER) ? white_zero_s : black_zero_s;
    // The mover's clock runs out on this wrap if it holds one second (or nothing).
    assign mover_last_s = mover_zero_s || (mover_secs_s == TIMER_WIDTH'(1));

    player_countdown #(
        .START_SECONDS     (START_SECONDS),
        .INCREMENT_SECONDS (INCREMENT_SECONDS),
        .TIMER_WIDTH       (TIMER_WIDTH)
    ) u_white (
        .OutClock  (OutClock),
        .resetApp  (resetApp),
        .en_i      (player_q == WHITE_PLAYER),
        .dec_i     (dec_s),
        .add_i     (add_s),
        .seconds_o (white_secs_s),
        .zero_o    (white_zero_s)
    );

    player_countdown #(
        .START_SECONDS     (START_SECONDS),
        .INCREMENT_SECONDS (INCREMENT_SECONDS),
        .TIMER_WIDTH       (TIMER_WIDTH)
    ) u_black (
        .OutClock  (OutClock),
        .resetApp  (resetApp),
        .en_i      (player_q == BLACK_PLAYER),
        .dec_i     (dec_s),
        .add_i     (add_s),
        .seconds_o (black_secs_s),
        .zero_o    (black_zero_s)
    );

    // Next-state logic: move arbitration, tick/second accounting, pause and game over.
    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        tick_d   = tick_q;
        count_d  = count_q;
        winner_d = winner_q;
        grant_d  = 1'b0;
        reject_d = 1'b0;
        dec_s    = 1'b0;
        add_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                reject_d = move_bus.MoveReq;
                if (StartGame) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (move_bus.MoveReq && move_bus.MoveValid) begin
                    // A legal move beats a same-cycle expiry and freezes the tick.
                    grant_d = 1'b1;
                    state_d = ST_COMMIT;
                end else if (PauseSwitch && !move_bus.MoveReq) begin
                    state_d = ST_PAUSE;
                end else begin
                    // An illegal request is rejected while the clock keeps running.
                    reject_d = move_bus.MoveReq;
                    if (tick_wrap_s) begin
                        tick_d = {TICK_W{1'b0}};
                        dec_s  = 1'b1;
                        if (mover_last_s) begin
                            state_d  = ST_OVER;
                            winner_d = ~player_q;
                        end else begin
                            state_d  = ST_RUN;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                reject_d = move_bus.MoveReq;
                add_s    = 1'b1;
                player_d = ~player_q;
                tick_d   = {TICK_W{1'b0}};
                count_d  = sat_inc8(count_q);
                if (PauseSwitch) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                reject_d = move_bus.MoveReq;
                if (!PauseSwitch) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_OVER: begin
                reject_d = move_bus.MoveReq;
                state_d  = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scheduler state registers; reset restores a fresh game with white to move.
    always_ff @(posedge OutClock or posedge resetApp) begin
        if (resetApp) begin
            state_q  <= ST_IDLE;
            player_q <= WHITE_PLAYER;
            tick_q   <= {TICK_W{1'b0}};
            count_q  <= 8'd0;
            grant_q  <= 1'b0;
            reject_q <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            tick_q   <= tick_d;
            count_q  <= count_d;
            grant_q  <= grant_d;
            reject_q <= reject_d;
            winner_q <= winner_d;
        end
    end

    assign move_bus.MoveGrant  = grant_q;
    assign move_bus.MoveReject = reject_q;
    assign Player              = player_q;
    assign WhiteSeconds        = white_secs_s;
    assign BlackSeconds        = black_secs_s;
    assign MoveCount           = count_q;
    assign GameState           = state_q;
    assign Winner              = winner_q;

endmodule

// File: doc/chess_turn_scheduler.md
# chess_turn_scheduler

Turn scheduler and game clock for the timed chess game. Owns whose turn it is, arbitrates move-commit requests from the layout-matrix datapath, grants or rejects each request, and runs per-player countdown clocks with optional per-move increment. Sits beside the layout matrix on the 10 Hz `OutClock` domain; its `Player` output selects which side the layout block may lock and move.

## Interface
Parameters:
- `TICKS_PER_SECOND`, 10: `OutClock` cycles per game second.
- `START_SECONDS`, 300: initial time per player.
- `INCREMENT_SECONDS`, 0: bonus added to mover's clock on each granted move.
- `TIMER_WIDTH`, 10: width of second counters; must hold `START_SECONDS` and the saturation value.

Ports:
- `OutClock` in 1: clock, 10 Hz.
- `resetApp` in 1: reset, asynchronous, active-high.
- `StartGame` in 1: single-cycle pulse, starts game from IDLE.
- `PauseSwitch` in 1: level; 1 freezes clocks.
- `MoveReq` in 1: single-cycle pulse from layout block on lock release.
- `MoveValid` in 1: legality result, sampled only with `MoveReq`.
- `MoveGrant` out 1: one-cycle pulse, commit the move.
- `MoveReject` out 1: one-cycle pulse, discard the move.
- `Player` out 1: side to move, 1 = white, 0 = black.
- `WhiteSeconds` out `TIMER_WIDTH`: white remaining seconds.
- `BlackSeconds` out `TIMER_WIDTH`: black remaining seconds.
- `MoveCount` out 8: granted moves, saturates at 255.
- `GameState` out 3: IDLE=0, RUN=1, COMMIT=2, PAUSE=3, OVER=4.
- `Winner` out 1: valid only in OVER; 1 = white won.

## Operation
- Reset values: state IDLE, `Player`=1, both clocks `START_SECONDS`, tick counter 0, `MoveCount`=0, `MoveGrant`=`MoveReject`=0, `Winner`=0.
- IDLE: clocks frozen. `StartGame` -> RUN. `MoveReq` -> reject.
- RUN: tick counter counts 0..`TICKS_PER_SECOND`-1 for the side to move. At wrap, decrement that side's seconds. A decrement to 0 -> OVER, `Winner` = opponent.
  - `MoveReq` with `MoveValid`=1 -> grant, go to COMMIT; no tick or decrement that cycle. Move wins over a same-cycle expiry.
  - `MoveReq` with `MoveValid`=0 -> reject; stay in RUN; ticking continues.
  - `PauseSwitch`=1 with no `MoveReq` -> PAUSE. If both occur in the same cycle, the request is served first and PAUSE is entered on the following cycle.
- COMMIT, exactly one cycle:
  - Mover's seconds += `INCREMENT_SECONDS`, saturating at 2^`TIMER_WIDTH`-1.
  - `Player` toggles.
  - Tick counter clears.
  - `MoveCount` increments, saturating.
  - Next state: RUN, or PAUSE if `PauseSwitch`=1.
  - `MoveReq` in COMMIT -> reject.
- PAUSE: counters hold; `MoveReq` -> reject; `PauseSwitch`=0 -> RUN, tick counter resumes from its held value.
- OVER: everything frozen until `resetApp`; `MoveReq` -> reject; `StartGame` ignored.
- Every `MoveReq` gets exactly one response pulse. Grant and reject are never asserted together.
- Seconds counters never underflow below 0.

## Timing
- All state is registered on posedge `OutClock`. Async reset has effect at once.
- Response latency: `MoveReq` sampled at edge N -> `MoveGrant`/`MoveReject` high for the cycle after edge N, low after edge N+1.
- `Player` toggles at edge N+1 (COMMIT -> RUN), one cycle after grant is visible. The layout block must not lock a new piece while `MoveGrant` is high.
- Decrement visible the cycle after the wrap edge. A full second is exactly `TICKS_PER_SECOND` RUN cycles of the same player.
- Reset mid-COMMIT: the move is not counted, `Player` returns to 1, and no response pulse follows.

## Structure
- Shared package `chess_pkg`:
  - `WHITE_PLAYER`/`BLACK_PLAYER`.
  - Game-state encodings.
  - Chessman codes, shared with the layout matrix.
- Sub-module `player_countdown`, instantiated twice (white, black).
  - Ports: enable, decrement strobe, add-increment strobe.
  - Outputs: seconds value and a zero flag.
  - Saturating add, floor at 0.
- The tick counter and FSM stay in the top module; the tick counter is shared because only one side runs at a time.

## Test plan
- Reset then `StartGame`, `TICKS_PER_SECOND`=10, `START_SECONDS`=3, no moves -> `WhiteSeconds` 3->2->1->0 every 10 cycles; OVER, `Winner`=0, `BlackSeconds`=3.
- In RUN, `MoveReq`+`MoveValid`=1 -> `MoveGrant` pulse 1 cycle; `Player` 1->0 next cycle; `MoveCount`=1; black's ticks start from 0.
- `MoveReq`+`MoveValid`=0 -> one `MoveReject` pulse; `Player` unchanged; white clock keeps decrementing.
- `INCREMENT_SECONDS`=5, `TIMER_WIDTH`=4, white at 13, grant -> white=15 (saturated), turn passes to black.
- `PauseSwitch` high for 25 cycles mid-second -> both clocks and tick counter unchanged; `MoveReq` during pause rejected; release resumes with the remaining ticks of that second.
- White at 1 s, tick 9, `MoveReq` valid on the wrap cycle -> grant, no timeout, white stays 1.
- Pulse `resetApp` during COMMIT -> all outputs at reset values, no response pulse.
